fp_divider: RTL and testbench
=============================

FP_DIVIDER -- requirements
Module: fp_divider

Interface
- REQ-001: The block SHALL have these ports:
  - clk, input, 1, the only clock; all state changes on its rising edge.
  - rst_n, input, 1, asynchronous active-low reset.
- REQ-002: It SHALL have these input ports:
  - n1, input, 32, IEEE-754 single-precision dividend.
  - n2, input, 32, IEEE-754 single-precision divisor.
  - in_valid, input, 1, n1/n2 valid.
  - out_ready, input, 1, consumer accepts result.
- REQ-003: It SHALL have these output ports:
  - in_ready, output, 1, block can accept an operation.
  - out_valid, output, 1, result and flags valid.
  - result, output, 32, IEEE-754 quotient, truncated (no rounding).
  - Overflow, output, 1, quotient exponent too large.
  - Underflow, output, 1, quotient exponent too small.
  - Exception, output, 1, an operand has exponent 0xFF (Inf/NaN).
  - DivByZero, output, 1, divisor is zero.
- REQ-004: The block SHALL have one clock domain (clk) and an asynchronous, active-low reset (rst_n).

Function
- REQ-005: The FSM SHALL have four states: IDLE, DIV, NORM, DONE. in_ready SHALL be 1 only in IDLE. out_valid SHALL be 1 only in DONE.
- REQ-006: An operation SHALL be accepted on a clk edge where state is IDLE and in_valid=1. On that edge, n1 and n2 SHALL be captured into internal registers.
- REQ-007: Operands SHALL be decoded as follows:
  - sign = n1[31]^n2[31].
  - Exponent field 0 (zero or denormal) SHALL be treated as zero (flush).
  - Mantissa SHALL be {1, frac[22:0]}, 24 bits.
- REQ-008: Special cases SHALL be checked at acceptance, with priority (first match wins):
  - Either exponent is 0xFF: result {sign,0xFF,23'h0}, Exception=1.
  - Divisor exponent is 0: result {sign,0xFF,23'h0}, DivByZero=1.
  - Dividend exponent is 0: result {sign,31'h0}, no flag set.
- REQ-009: For a special case, the acceptance edge SHALL go IDLE->DONE, so out_valid is high 1 cycle after acceptance.
- REQ-010: For a normal operation, the acceptance edge SHALL go IDLE->DIV and load:
  - Remainder = dividend mantissa.
  - Quotient = 0.
  - Bit counter = 24.
  - Biased exponent E = e1 - e2 + 127, as a 10-bit signed value (range -126..380).
- REQ-011: DIV SHALL perform restoring division, one quotient bit per cycle, for exactly 25 cycles (counter 24 down to 0):
  - If remainder >= divisor mantissa, subtract and shift in 1; otherwise shift in 0.
  - Then shift the remainder left by 1.
  - The end result is q = floor((m1<<24)/m2), 25 bits.
- REQ-012: When the counter reaches 0, DIV SHALL go to NORM.
- REQ-013: In NORM, normalisation SHALL be:
  - If q[24]=1: mantissa = q[23:1], exponent = E.
  - Otherwise: mantissa = q[22:0], exponent = E-1.
- REQ-014: In NORM, the final exponent Ef SHALL be range-checked:
  - Ef >= 255 (signed): Overflow=1, result {sign,0xFF,23'h0}.
  - Ef <= 0 (signed): Underflow=1, result {sign,31'h0}.
  - Otherwise: result {sign, Ef[7:0], mantissa}.
- REQ-015: The result and flags SHALL be registered on the NORM->DONE edge. Normal-case latency SHALL be 27 clk edges from the acceptance edge to the first cycle with out_valid=1.
- REQ-016: In DONE, result and all flags SHALL hold stable while out_ready=0.
- REQ-017: DONE SHALL go to IDLE on an edge with out_ready=1. No new operation SHALL be accepted on that same edge.
- REQ-018: Flags SHALL be mutually exclusive. All flags SHALL be cleared at each acceptance.
- REQ-019: Changes on n1/n2/in_valid outside an acceptance edge SHALL NOT affect an operation in flight.

Reset
- REQ-020: While rst_n=0, regardless of clk, the block SHALL hold:
  - state = IDLE, in_ready=1, out_valid=0.
  - result=0, all flags 0.
  - Quotient, remainder and counter = 0.
- REQ-021: Reset asserted in DIV, NORM or DONE SHALL abort the operation without producing a result. The first edge after rst_n deasserts SHALL be able to accept a new operation.

Verification
- REQ-022: The bench SHALL cover these directed scenarios:
  - 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, all flags 0, out_valid exactly 27 edges after acceptance.
  - 0x3F800000 / 0x40400000 (1.0/3.0, q[24]=0 path) -> result 0x3EAAAAAA (truncated).
  - 0xBF800000 / 0x00000000 -> result 0xFF800000, DivByZero=1, out_valid 1 cycle after acceptance. Also 0x7FC00000 / 0x3F800000 -> 0x7F800000, Exception=1.
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, Overflow=1. Also 0x00800000 / 0x40000000 -> 0x00000000, Underflow=1.
  - out_ready held 0 for 10 cycles in DONE -> result stable, in_ready=0. Then out_ready=1 -> IDLE next edge; a back-to-back second operation is correct.
  - rst_n pulsed low mid-DIV (counter 12) -> out_valid=0, in_ready=1 immediately. The next 6.0/2.0 operation yields 0x40400000.

Source files
------------

// File: rtl/fp_divider.sv
// Single-precision floating-point divider: truncating quotient, one restoring
// division bit per cycle, with IEEE special-case and exponent range flags.
module fp_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] n1,
  input  logic [31:0] n2,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Exception,
  output logic        DivByZero
);

  localparam int DATA_W = 32;
  localparam int MANT_W = 24;
  localparam int QUO_W  = 25;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     sign_r;
  logic signed [9:0]        exp_r;
  logic [MANT_W-1:0]        m2_r;
  logic [QUO_W-1:0]         rem_r;
  logic [QUO_W-1:0]         quo_r;
  logic [4:0]               cnt_r;

  // acceptance-time operand decode
  logic                     sign_in;
  logic [7:0]               e1, e2;
  logic [MANT_W-1:0]        m1_in, m2_in;
  logic signed [9:0]        exp_in;
  logic                     is_exc, is_dbz, is_zero, is_special;
  logic                     accept;

  // division step and normalisation
  logic                     rem_ge;
  logic [QUO_W-1:0]         rem_next;
  logic [22:0]              norm_mant;
  logic signed [9:0]        norm_exp;
  logic [DATA_W+1:0]        norm_pack;

  // Range-check the final exponent: returns {overflow, underflow, result}.
  function automatic logic [DATA_W+1:0] range_pack(input logic s,
                                                    input logic signed [9:0] ef,
                                                    input logic [22:0] m);
    if (ef >= 10'sd255)
      range_pack = {2'b10, s, 8'hFF, 23'h0};
    else if (ef <= 10'sd0)
      range_pack = {2'b01, s, 31'h0};
    else
      range_pack = {2'b00, s, ef[7:0], m};
  endfunction

  always_comb begin
    sign_in    = n1[31] ^ n2[31];
    e1         = n1[30:23];
    e2         = n2[30:23];
    m1_in      = {1'b1, n1[22:0]};
    m2_in      = {1'b1, n2[22:0]};
    exp_in     = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
    is_exc     = (e1 == 8'hFF) || (e2 == 8'hFF);
    is_dbz     = !is_exc && (e2 == 8'h00);
    is_zero    = !is_exc && !is_dbz && (e1 == 8'h00);
    is_special = is_exc || is_dbz || is_zero;
    accept     = (state == IDLE) && in_valid;
  end

  always_comb begin
    rem_ge    = rem_r >= {1'b0, m2_r};
    rem_next  = rem_ge ? (rem_r - {1'b0, m2_r}) : rem_r;
    norm_mant = quo_r[24] ? quo_r[23:1] : quo_r[22:0];
    norm_exp  = quo_r[24] ? exp_r : (exp_r - 10'sd1);
    norm_pack = range_pack(sign_r, norm_exp, norm_mant);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = is_special ? DONE : DIV;
      end
      DIV:  if (cnt_r == 5'd0) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r    <= 1'b0;
      exp_r     <= '0;
      m2_r      <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      cnt_r     <= '0;
      result    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Exception <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_r    <= sign_in;
          Overflow  <= 1'b0;
          Underflow <= 1'b0;
          Exception <= is_exc;
          DivByZero <= is_dbz;
          if (is_exc || is_dbz)
            result <= {sign_in, 8'hFF, 23'h0};
          else if (is_zero)
            result <= {sign_in, 31'h0};
          else begin
            exp_r <= exp_in;
            m2_r  <= m2_in;
            rem_r <= {1'b0, m1_in};
            quo_r <= '0;
            cnt_r <= 5'd24;
          end
        end
        DIV: begin
          rem_r <= rem_next << 1;
          quo_r <= {quo_r[QUO_W-2:0], rem_ge};
          if (cnt_r != 5'd0) cnt_r <= cnt_r - 5'd1;
        end
        // final exponent range check; flags and result latch here
        NORM: begin
          Overflow  <= norm_pack[DATA_W+1];
          Underflow <= norm_pack[DATA_W];
          result    <= norm_pack[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed IEEE cases, randomized operands against a
// plain-arithmetic quotient model, stall/back-to-back and mid-operation reset.
module tb_fp_divider;

  logic        clk, rst_n;
  logic [31:0] n1, n2;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic        Overflow, Underflow, Exception, DivByZero;

  int checks   = 0;
  int failures = 0;

  fp_divider dut (
    .clk(clk), .rst_n(rst_n), .n1(n1), .n2(n2),
    .in_valid(in_valid), .out_ready(out_ready),
    .in_ready(in_ready), .out_valid(out_valid), .result(result),
    .Overflow(Overflow), .Underflow(Underflow),
    .Exception(Exception), .DivByZero(DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {Overflow, Underflow, Exception, DivByZero, result}
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, ef;
    longint ma, mb, q, mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {4'b0010, s, 8'hFF, 23'h0};
    if (eb == 0)                return {4'b0001, s, 8'hFF, 23'h0};
    if (ea == 0)                return {4'b0000, s, 31'h0};
    ma = longint'(a[22:0]) + 64'd8388608;
    mb = longint'(b[22:0]) + 64'd8388608;
    q  = (ma * 64'd16777216) / mb;
    e  = ea - eb + 127;
    if (q >= 64'd16777216) begin
      mant = (q / 2) % 64'd8388608;
      ef   = e;
    end else begin
      mant = q % 64'd8388608;
      ef   = e - 1;
    end
    if (ef >= 255) return {4'b1000, s, 8'hFF, 23'h0};
    if (ef <= 0)   return {4'b0100, s, 31'h0};
    return {4'b0000, s, ef[7:0], mant[22:0]};
  endfunction

  function automatic logic [35:0] observed();
    return {Overflow, Underflow, Exception, DivByZero, result};
  endfunction

  // Launch one operation; lat counts edges from acceptance (inclusive) to out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    n1 = a; n2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n1 = $urandom; n2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; n1 = '0; n2 = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    checks++;
    if (observed() !== 36'h0) begin
      failures++;
      $display("FAIL reset_out got=%h exp=%h", observed(), 36'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [35:0] e [6];
    int          l [6];
    int lat;
    a[0] = 32'h40C00000; b[0] = 32'h40000000; e[0] = {4'b0000, 32'h40400000}; l[0] = 27;
    a[1] = 32'h3F800000; b[1] = 32'h40400000; e[1] = {4'b0000, 32'h3EAAAAAA}; l[1] = 27;
    a[2] = 32'hBF800000; b[2] = 32'h00000000; e[2] = {4'b0001, 32'hFF800000}; l[2] = 1;
    a[3] = 32'h7FC00000; b[3] = 32'h3F800000; e[3] = {4'b0010, 32'h7F800000}; l[3] = 1;
    a[4] = 32'h7F000000; b[4] = 32'h3E800000; e[4] = {4'b1000, 32'h7F800000}; l[4] = 27;
    a[5] = 32'h00800000; b[5] = 32'h40000000; e[5] = {4'b0100, 32'h00000000}; l[5] = 27;
    for (int i = 0; i < 6; i++) begin
      run_op(a[i], b[i], lat);
      checks++;
      if (observed() !== e[i]) begin
        failures++;
        $display("FAIL directed_%0d got=%h exp=%h", i, observed(), e[i]);
      end
      checks++;
      if (lat !== l[i]) begin
        failures++;
        $display("FAIL directed_lat_%0d got=%0d exp=%0d", i, lat, l[i]);
      end
      release_op();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [35:0] exp_v;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: a[30:23] = 8'hFF;
        1: b[30:23] = 8'h00;
        2: a[30:23] = 8'h00;
        3: begin a[30:23] = 8'(200 + $urandom_range(0, 54)); b[30:23] = 8'($urandom_range(1, 60)); end
        4: begin a[30:23] = 8'($urandom_range(1, 60)); b[30:23] = 8'(190 + $urandom_range(0, 64)); end
        default: begin
          a[30:23] = 8'($urandom_range(64, 190));
          b[30:23] = 8'($urandom_range(64, 190));
        end
      endcase
      exp_v   = model(a, b);
      exp_lat = (a[30:23] == 8'hFF || b[30:23] == 8'hFF ||
                 b[30:23] == 8'h00 || a[30:23] == 8'h00) ? 1 : 27;
      run_op(a, b, lat);
      checks++;
      if (observed() !== exp_v) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h got=%h exp=%h", i, a, b, observed(), exp_v);
      end
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL random_lat_%0d got=%0d exp=%0d", i, lat, exp_lat);
      end
      release_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] held;
    int lat;
    run_op(32'h41200000, 32'h40800000, lat);
    held = observed();
    checks++;
    if (held !== model(32'h41200000, 32'h40800000)) begin
      failures++;
      $display("FAIL stall_first got=%h exp=%h", held, model(32'h41200000, 32'h40800000));
    end
    n1 = 32'h40C00000; n2 = 32'h40000000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (observed() !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d got=%h ov=%b ir=%b exp=%h ov=1 ir=0",
                 i, observed(), out_valid, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL release_idle got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    run_op(32'hC2F60000, 32'h3FC00000, lat);
    checks++;
    if (observed() !== model(32'hC2F60000, 32'h3FC00000) || lat !== 27) begin
      failures++;
      $display("FAIL back_to_back got=%h lat=%0d exp=%h lat=27",
               observed(), lat, model(32'hC2F60000, 32'h3FC00000));
    end
    release_op();
  endtask

  task automatic test_reset_mid_div();
    int lat;
    n1 = 32'h40C00000; n2 = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || observed() !== 36'h0) begin
      failures++;
      $display("FAIL reset_mid_div got in_ready=%b out_valid=%b out=%h exp 1 0 0",
               in_ready, out_valid, observed());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_result got out_valid=%b exp 0", out_valid);
    end
    run_op(32'h40C00000, 32'h40000000, lat);
    checks++;
    if (observed() !== {4'b0000, 32'h40400000} || lat !== 27) begin
      failures++;
      $display("FAIL after_reset got=%h lat=%0d exp=%h lat=27",
               observed(), lat, {4'b0000, 32'h40400000});
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
